// File: rtl/laser_host.sv
// laser_host: buffers a frame of 4-bit (x,y) points, streams them to an external
// circle-fitting engine, waits for the two returned centers, then scores how many
// buffered points fall inside either circle of squared radius RADIUS_SQ.
// Optional feature macro: LASER_HOST_TIMEOUT_EN adds a WAIT watchdog and a
// TIMEOUT output; without it WAIT waits for DONE indefinitely.
module laser_host #(
   parameter int NPTS      = 40,
   parameter int RADIUS_SQ = 16
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       LD_EN,
   input  logic [5:0] LD_ADDR,
   input  logic [3:0] LD_X,
   input  logic [3:0] LD_Y,
   input  logic       START,
   output logic       BUSY,
   output logic       LRST,
   output logic [3:0] X,
   output logic [3:0] Y,
   input  logic       DONE,
   input  logic [3:0] C1X,
   input  logic [3:0] C1Y,
   input  logic [3:0] C2X,
   input  logic [3:0] C2Y,
   output logic [5:0] SCORE,
   output logic       VALID
`ifdef LASER_HOST_TIMEOUT_EN
   ,
   output logic       TIMEOUT
`endif
);

   typedef enum logic [2:0] {
      S_IDLE, S_LRST, S_SEND, S_WAIT, S_SCORE, S_REPORT, S_ERR
   } state_t;

   localparam logic [5:0] LAST = 6'(NPTS - 1);
   localparam logic [5:0] NPTS_W = 6'(NPTS);
   localparam logic [8:0] RSQ = 9'(RADIUS_SQ);

   // Point buffer: {x,y} per entry; deliberately not reset so a frame abort keeps it
   logic [7:0] pbuf_q [NPTS];

   state_t     state_q, state_d;
   logic [5:0] idx_q, idx_d;
   logic [5:0] cnt_q, cnt_d;
   logic [5:0] score_q, score_d;
   logic [15:0] cen_q, cen_d;
`ifdef LASER_HOST_TIMEOUT_EN
   logic [11:0] wcnt_q, wcnt_d;
   logic        timeout_q, timeout_d;
`endif

   logic       wr_en;
   logic [7:0] pt;
   logic       covered;

   // True when point (px,py) lies within squared radius of center (cx,cy); full-width math
   function automatic logic in_circle(input logic [3:0] px, input logic [3:0] py,
                                      input logic [3:0] cx, input logic [3:0] cy);
      logic [3:0] adx, ady;
      logic [7:0] sqx, sqy;
      logic [8:0] sum;
      adx = (px >= cx) ? (px - cx) : (cx - px);
      ady = (py >= cy) ? (py - cy) : (cy - py);
      sqx = {4'd0, adx} * {4'd0, adx};
      sqy = {4'd0, ady} * {4'd0, ady};
      sum = {1'b0, sqx} + {1'b0, sqy};
      return (sum <= RSQ);
   endfunction

   assign wr_en   = LD_EN && (state_q == S_IDLE) && (LD_ADDR < NPTS_W);
   assign pt      = pbuf_q[idx_q];
   assign covered = in_circle(pt[7:4], pt[3:0], cen_q[15:12], cen_q[11:8]) ||
                    in_circle(pt[7:4], pt[3:0], cen_q[7:4],   cen_q[3:0]);

   // Buffer write port; reset still blocks writes but never clears contents
   always_ff @(posedge CLK) begin
      if (RST_N && wr_en) pbuf_q[LD_ADDR] <= {LD_X, LD_Y};
   end

   // Next-state and datapath updates for the frame sequencer
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      score_d = score_q;
      cen_d   = cen_q;
`ifdef LASER_HOST_TIMEOUT_EN
      wcnt_d    = '0;
      timeout_d = timeout_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (START) state_d = S_LRST;
         end
         S_LRST: begin
            idx_d   = '0;
            state_d = S_SEND;
         end
         S_SEND: begin
            if (idx_q == LAST) begin
               idx_d   = '0;
               state_d = S_WAIT;
            end else begin
               idx_d = idx_q + 6'd1;
            end
         end
         S_WAIT: begin
            if (DONE) begin
               cen_d   = {C1X, C1Y, C2X, C2Y};
               cnt_d   = '0;
               idx_d   = '0;
               state_d = S_SCORE;
            end
`ifdef LASER_HOST_TIMEOUT_EN
            else if (wcnt_q == 12'hFFF) begin
               timeout_d = 1'b1;
               state_d   = S_ERR;
            end else begin
               wcnt_d = wcnt_q + 12'd1;
            end
`endif
         end
         S_SCORE: begin
            cnt_d = cnt_q + {5'd0, covered};
            if (idx_q == LAST) begin
               score_d = cnt_d;
               idx_d   = '0;
               state_d = S_REPORT;
            end else begin
               idx_d = idx_q + 6'd1;
            end
         end
         S_REPORT: begin
            state_d = S_IDLE;
         end
         S_ERR: begin
            if (START) begin
`ifdef LASER_HOST_TIMEOUT_EN
               timeout_d = 1'b0;
`endif
               state_d = S_LRST;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers with synchronous active-low reset
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         score_q <= '0;
         cen_q   <= '0;
`ifdef LASER_HOST_TIMEOUT_EN
         wcnt_q    <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         score_q <= score_d;
         cen_q   <= cen_d;
`ifdef LASER_HOST_TIMEOUT_EN
         wcnt_q    <= wcnt_d;
         timeout_q <= timeout_d;
`endif
      end
   end

   assign BUSY  = (state_q != S_IDLE);
   assign LRST  = (state_q == S_LRST);
   assign X     = (state_q == S_SEND) ? pt[7:4] : 4'd0;
   assign Y     = (state_q == S_SEND) ? pt[3:0] : 4'd0;
   assign VALID = (state_q == S_REPORT);
   assign SCORE = score_q;
`ifdef LASER_HOST_TIMEOUT_EN
   assign TIMEOUT = timeout_q;
`endif

endmodule

// File: tb/tb_laser_host.sv
// Directed bench for laser_host: streaming order, scoring, boundaries, reset abort.
module tb_laser_host;
   logic       CLK = 1'b0;
   logic       RST_N, LD_EN, START, DONE;
   logic [5:0] LD_ADDR;
   logic [3:0] LD_X, LD_Y, C1X, C1Y, C2X, C2Y;
   logic       BUSY, LRST, VALID;
   logic [3:0] X, Y;
   logic [5:0] SCORE;
`ifdef LASER_HOST_TIMEOUT_EN
   logic       TIMEOUT;
`endif

   int nvec = 0;
   int nerr = 0;

   laser_host #(.NPTS(40), .RADIUS_SQ(16)) dut (
      .CLK(CLK), .RST_N(RST_N), .LD_EN(LD_EN), .LD_ADDR(LD_ADDR),
      .LD_X(LD_X), .LD_Y(LD_Y), .START(START), .BUSY(BUSY), .LRST(LRST),
      .X(X), .Y(Y), .DONE(DONE), .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y),
      .SCORE(SCORE), .VALID(VALID)
`ifdef LASER_HOST_TIMEOUT_EN
      , .TIMEOUT(TIMEOUT)
`endif
   );

   always #5 CLK = ~CLK;

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic load(input int a, input logic [3:0] x, input logic [3:0] y);
      LD_EN = 1'b1; LD_ADDR = a[5:0]; LD_X = x; LD_Y = y;
      tick;
      LD_EN = 1'b0;
   endtask

   // From WAIT: present centers with DONE, then expect REPORT 40 cycles later
   task automatic finish_frame(input logic [3:0] ax, input logic [3:0] ay,
                               input logic [3:0] bx, input logic [3:0] by,
                               input logic [5:0] exp, input string tag);
      DONE = 1'b1; C1X = ax; C1Y = ay; C2X = bx; C2Y = by;
      tick;
      DONE = 1'b0;
      C1X = 4'($urandom); C1Y = 4'($urandom); C2X = 4'($urandom); C2Y = 4'($urandom);
      for (int i = 0; i < 40; i++) begin
         chk({tag, "_valid_low"}, VALID, 0);
         tick;
      end
      chk({tag, "_valid"}, VALID, 1);
      chk({tag, "_score"}, SCORE, exp);
   endtask

   task automatic frame(input logic [3:0] ax, input logic [3:0] ay,
                        input logic [3:0] bx, input logic [3:0] by,
                        input logic [5:0] exp, input string tag);
      START = 1'b1;
      tick;
      START = 1'b0;
      repeat (41) tick;
      chk({tag, "_wait_busy"}, BUSY, 1);
      finish_frame(ax, ay, bx, by, exp, tag);
      tick;
      chk({tag, "_valid_drop"}, VALID, 0);
      chk({tag, "_idle"}, BUSY, 0);
   endtask

   // Full stream of the (k%16, k/16) pattern; DONE held high during SEND to prove it is ignored
   task automatic stream(input string tag);
      START = 1'b1;
      tick;
      START = 1'b0;
      chk({tag, "_lrst"}, LRST, 1);
      chk({tag, "_lrst_busy"}, BUSY, 1);
      chk({tag, "_lrst_x"}, X, 0);
      DONE = 1'b1;
      tick;
      for (int k = 0; k < 40; k++) begin
         chk({tag, "_send_lrst"}, LRST, 0);
         chk({tag, "_x"}, X, k % 16);
         chk({tag, "_y"}, Y, k / 16);
         tick;
      end
      DONE = 1'b0;
      chk({tag, "_x_after"}, X, 0);
      chk({tag, "_y_after"}, Y, 0);
      chk({tag, "_wait_busy"}, BUSY, 1);
   endtask

   initial begin
      RST_N = 1'b0; LD_EN = 1'b0; LD_ADDR = '0; LD_X = '0; LD_Y = '0;
      START = 1'b0; DONE = 1'b0; C1X = '0; C1Y = '0; C2X = '0; C2Y = '0;
      tick; tick;
      chk("rst_busy", BUSY, 0);
      chk("rst_lrst", LRST, 0);
      chk("rst_x", X, 0);
      chk("rst_y", Y, 0);
      chk("rst_score", SCORE, 0);
      chk("rst_valid", VALID, 0);
`ifdef LASER_HOST_TIMEOUT_EN
      chk("rst_timeout", TIMEOUT, 0);
`endif
      RST_N = 1'b1;
      tick;

      // Ramp pattern and full streaming check
      for (int k = 0; k < 40; k++) load(k, 4'(k % 16), 4'(k / 16));
      stream("ramp");
      // Writes outside IDLE must be dropped: point 0 stays (0,0)
      load(0, 4'd15, 4'd15);
      tick; tick;
      chk("ramp_still_wait", BUSY, 1);
      chk("ramp_no_early_valid", VALID, 0);
      // c1=(0,0): 5+4+4 points; c2=(15,2): 4+4 points -> 21
      finish_frame(4'd0, 4'd0, 4'd15, 4'd2, 6'd21, "ramp");
      START = 1'b1;           // coincides with REPORT -> ignored
      tick;
      START = 1'b0;
      chk("report_start_ignored", BUSY, 0);
      chk("score_hold", SCORE, 21);
      tick;
      chk("report_start_idle", BUSY, 0);

      // Reset in SEND cycle 20, with START asserted alongside it
      START = 1'b1;
      tick;
      START = 1'b0;
      repeat (21) tick;
      chk("abort_x20", X, 4);
      chk("abort_y20", Y, 1);
      RST_N = 1'b0; START = 1'b1;
      tick;
      RST_N = 1'b1; START = 1'b0;
      chk("abort_busy", BUSY, 0);
      chk("abort_x", X, 0);
      chk("abort_y", Y, 0);
      chk("abort_lrst", LRST, 0);
      chk("abort_score", SCORE, 0);
      stream("restream");
      finish_frame(4'd0, 4'd0, 4'd15, 4'd2, 6'd21, "restream");
      tick;

      // All points at (8,8): fully covered by c1
      for (int k = 0; k < 40; k++) load(k, 4'd8, 4'd8);
      frame(4'd8, 4'd8, 4'd0, 4'd0, 6'd40, "all_in");
      // Same point in both circles counts once
      frame(4'd8, 4'd8, 4'd8, 4'd8, 6'd40, "both");

      // All at origin, centers far away
      for (int k = 0; k < 40; k++) load(k, 4'd0, 4'd0);
      frame(4'd15, 4'd15, 4'd10, 4'd10, 6'd0, "none_in");

      // Boundary: sum 16 in, sum 17 out
      load(0, 4'd4, 4'd0);
      load(1, 4'd4, 4'd1);
      for (int k = 2; k < 40; k++) load(k, 4'd15, 4'd15);
      frame(4'd0, 4'd0, 4'd0, 4'd15, 6'd1, "boundary");

`ifdef LASER_HOST_TIMEOUT_EN
      START = 1'b1;
      tick;
      START = 1'b0;
      repeat (40) tick;
      repeat (4095) tick;
      chk("to_pending", TIMEOUT, 0);
      chk("to_pending_busy", BUSY, 1);
      tick;
      chk("to_set", TIMEOUT, 1);
      chk("to_err_busy", BUSY, 1);
      START = 1'b1;
      tick;
      START = 1'b0;
      chk("to_clear", TIMEOUT, 0);
      chk("to_lrst", LRST, 1);
      RST_N = 1'b0;
      tick;
      RST_N = 1'b1;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
